lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller.
// Holds the access-size encoding, the controller FSM state enum and the
// helper that classifies an access as illegal (bad size or misaligned).
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      RESP   = 3'd5
   } state_e;

   // An access errors when its size code is reserved or when it is not
   // naturally aligned to its own size.
   function automatic logic lsu_is_err(input logic [1:0] size, input logic [1:0] lo);
      return (size == SZ_ILL)
          || ((size == SZ_HALF) && lo[0])
          || ((size == SZ_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   size_i     access size (lsu_pkg size encoding)
//   unsigned_i zero-extend sub-word loads when set
//   lane_i     byte address bits [1:0]
//   rword_i    word read from the data RAM
//   wdata_i    right-aligned store data
//   load_o     extracted and extended load value
//   merge_o    RAM word with the addressed byte/half replaced by store data
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic [1:0]           size_i,
   input  logic                 unsigned_i,
   input  logic [1:0]           lane_i,
   input  logic [DATAWIDTH-1:0] rword_i,
   input  logic [DATAWIDTH-1:0] wdata_i,
   output logic [DATAWIDTH-1:0] load_o,
   output logic [DATAWIDTH-1:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // Little-endian: byte lane n is bits [8n+7:8n]; half lane picked by addr[1].
      byte_sel = rword_i[{lane_i, 3'b000} +: 8];
      half_sel = rword_i[{lane_i[1], 4'b0000} +: 16];
      load_o   = rword_i;
      merge_o  = rword_i;
      case (size_i)
         SZ_BYTE: begin
            load_o = {{(DATAWIDTH-8){~unsigned_i & byte_sel[7]}}, byte_sel};
            merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o = {{(DATAWIDTH-16){~unsigned_i & half_sel[15]}}, half_sel};
            merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            // Word access: unsigned flag has no effect.
            load_o  = rword_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one CPU access at a time and
// drives a single-port data RAM with combinational read data. Sub-word
// stores are done as read-modify-write.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_*               CPU request (valid/ready handshake, fields latched on accept)
//   resp_valid          one-cycle completion pulse with resp_rdata / resp_err
//   mem_ena/wen/addr/din  RAM control, word-aligned address, write word
//   mem_dout            RAM read word, valid in the cycle mem_ena=1, mem_wen=0
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [DATAWIDTH-1:0] req_addr,
   input  logic [DATAWIDTH-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [DATAWIDTH-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 mem_ena,
   output logic                 mem_wen,
   output logic [DATAWIDTH-1:0] mem_addr,
   output logic [DATAWIDTH-1:0] mem_din,
   input  logic [DATAWIDTH-1:0] mem_dout
);

   state_e               state_q, state_d;
   logic                 we_q, we_d;
   logic [1:0]           size_q, size_d;
   logic                 uns_q, uns_d;
   logic [DATAWIDTH-1:0] addr_q, addr_d;
   logic [DATAWIDTH-1:0] wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [DATAWIDTH-1:0] rdata_q, rdata_d;
   logic [DATAWIDTH-1:0] merged_q, merged_d;
   logic [DATAWIDTH-1:0] load_ext;
   logic [DATAWIDTH-1:0] merged_w;

   lsu_align #(.DATAWIDTH(DATAWIDTH)) u_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .lane_i     (addr_q[1:0]),
      .rword_i    (mem_dout),
      .wdata_i    (wdata_q),
      .load_o     (load_ext),
      .merge_o    (merged_w)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      merged_d = merged_q;
      mem_ena  = 1'b0;
      mem_wen  = 1'b0;
      mem_din  = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               uns_d    = req_unsigned;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = lsu_is_err(req_size, req_addr[1:0]);
               // Cleared so stores and errors respond with zero data.
               rdata_d  = '0;
               merged_d = '0;
               if (err_d)                    state_d = RESP;
               else if (!req_we)             state_d = LOAD;
               else if (req_size == SZ_WORD) state_d = STORE;
               else                          state_d = RMW_RD;
            end
         end
         LOAD: begin
            mem_ena = 1'b1;
            rdata_d = load_ext;
            state_d = RESP;
         end
         STORE: begin
            mem_ena = 1'b1;
            mem_wen = 1'b1;
            mem_din = wdata_q;
            state_d = RESP;
         end
         RMW_RD: begin
            mem_ena  = 1'b1;
            merged_d = merged_w;
            state_d  = RMW_WR;
         end
         RMW_WR: begin
            mem_ena = 1'b1;
            mem_wen = 1'b1;
            mem_din = merged_q;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign mem_addr   = {addr_q[DATAWIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural RAM and a
// word-array reference model of memory and responses.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_ena;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   lsu_mem_ctrl #(.DATAWIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_ena      (mem_ena),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        mem_init = 1'b1;

   function automatic logic [31:0] init_word(input int i);
      return (32'h9E3779B9 * i) ^ 32'hC3A50F1E;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      end else if (mem_ena && mem_wen) begin
         ram[mem_addr[9:2]] <= mem_din;
      end
   end

   assign mem_dout = ram[mem_addr[9:2]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the access rules, on a plain word array.
   function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic err, output logic [31:0] rd,
                                 output logic [31:0] nw, output int lat);
      logic [31:0] w, v, mask;
      int sh;
      w   = ref_mem[a[9:2]];
      sh  = 8 * int'(a[1:0]);
      err = (sz == X) || (sz == H && a[0]) || (sz == W && a[1:0] != 2'b00);
      rd  = 32'h0;
      nw  = w;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         if (sz == B) begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
         end else if (sz == H) begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
         end else begin
            v = w;
         end
         rd = v;
      end else if (sz == W) begin
         lat = 2;
         nw  = wd;
      end else begin
         lat  = 3;
         mask = ((sz == B) ? 32'hFF : 32'hFFFF) << sh;
         nw   = (w & ~mask) | ((wd << sh) & mask);
      end
   endfunction

   // Called at a falling edge; returns at a falling edge one cycle after resp.
   task automatic do_req(input bit hold, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input string name, output logic [31:0] got);
      logic        e_err;
      logic [31:0] e_rd, e_nw;
      int          e_lat, cyc, ena_cnt, rdy_busy, bad_addr;
      model(we, sz, uns, a, wd, e_err, e_rd, e_nw, e_lat);
      got          = 32'h0;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      cyc = 0;
      while (!req_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!req_ready) begin
         chk({name, " accept_timeout"}, 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      cyc = 0; ena_cnt = 0; rdy_busy = 0; bad_addr = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (mem_ena) ena_cnt++;
         if (mem_ena && mem_addr[1:0] != 2'b00) bad_addr++;
         if (req_ready) rdy_busy++;
      end while (!resp_valid && cyc < 20);
      got = resp_rdata;
      chk({name, " resp_valid"}, 32'(resp_valid), 32'h1);
      chk({name, " latency"}, cyc, e_lat);
      chk({name, " rdata"}, resp_rdata, e_rd);
      chk({name, " err"}, 32'(resp_err), 32'(e_err));
      chk({name, " ready_busy"}, rdy_busy, 0);
      chk({name, " mem_addr_align"}, bad_addr, 0);
      chk({name, " mem_ena_cycles"}, ena_cnt, e_err ? 0 : e_lat - 1);
      if (we && !e_err) ref_mem[a[9:2]] = e_nw;
      @(negedge clk);
      chk({name, " pulse_end"}, 32'(resp_valid), 32'h0);
      chk({name, " idle_outs"}, {resp_rdata[30:0], resp_err}, 32'h0);
      chk({name, " ready_again"}, 32'(req_ready), 32'h1);
      chk({name, " ram_word"}, ram[a[9:2]], ref_mem[a[9:2]]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      repeat (3) @(negedge clk);
      chk("rst resp_valid", 32'(resp_valid), 32'h0);
      chk("rst resp_err", 32'(resp_err), 32'h0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst mem_ena", 32'(mem_ena), 32'h0);
      chk("rst mem_wen", 32'(mem_wen), 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_din", mem_din, 32'h0);
      mem_init = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      rst = 1'b1;
      @(negedge clk);
      chk("ready after reset", 32'(req_ready), 32'h1);

      // Word store then load.
      do_req(0, 1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, "sw10", got);
      chk("sw10 ram const", ram[4], 32'hDEADBEEF);
      do_req(0, 1'b0, W, 1'b0, 32'h10, 32'h0, "lw10", got);
      chk("lw10 const", got, 32'hDEADBEEF);

      // Byte store via read-modify-write.
      do_req(0, 1'b1, W, 1'b0, 32'h20, 32'h11223344, "sw20", got);
      do_req(0, 1'b1, B, 1'b0, 32'h22, 32'h000000AA, "sb22", got);
      chk("sb22 ram const", ram[8], 32'h11AA3344);

      // Load extension.
      do_req(0, 1'b1, W, 1'b0, 32'h30, 32'h8001F0FF, "sw30", got);
      do_req(0, 1'b0, B, 1'b0, 32'h30, 32'h0, "lb30", got);
      chk("lb30 const", got, 32'hFFFFFFFF);
      do_req(0, 1'b0, B, 1'b1, 32'h30, 32'h0, "lbu30", got);
      chk("lbu30 const", got, 32'h000000FF);
      do_req(0, 1'b0, H, 1'b0, 32'h32, 32'h0, "lh32", got);
      chk("lh32 const", got, 32'hFFFF8001);
      do_req(0, 1'b0, H, 1'b1, 32'h32, 32'h0, "lhu32", got);
      chk("lhu32 const", got, 32'h00008001);
      do_req(0, 1'b0, W, 1'b1, 32'h30, 32'h0, "lw30 uns", got);
      chk("lw30 const", got, 32'h8001F0FF);

      // Misaligned and illegal accesses.
      do_req(0, 1'b0, W, 1'b0, 32'h31, 32'h0, "lw31 misaligned", got);
      do_req(0, 1'b1, H, 1'b0, 32'h33, 32'h1234, "sh33 misaligned", got);
      do_req(0, 1'b0, X, 1'b0, 32'h30, 32'h0, "size11", got);

      // Reset during RMW_WR of sh 0xBEEF to 0x40.
      do_req(0, 1'b1, W, 1'b0, 32'h40, 32'h12345678, "sw40", got);
      req_valid = 1'b1; req_we = 1'b1; req_size = H; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rmw rd ena", {mem_ena, mem_wen}, 32'h2);
      @(negedge clk);
      chk("rmw wr ena", {mem_ena, mem_wen}, 32'h3);
      rst = 1'b0;
      #1;
      chk("midrst mem_ena", 32'(mem_ena), 32'h0);
      chk("midrst mem_wen", 32'(mem_wen), 32'h0);
      chk("midrst mem_addr", mem_addr, 32'h0);
      chk("midrst mem_din", mem_din, 32'h0);
      chk("midrst resp", {resp_rdata[29:0], resp_err, resp_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst ready", 32'(req_ready), 32'h1);
      chk("midrst ram", ram[16], 32'h12345678);
      chk("midrst ram model", ram[16], ref_mem[16]);

      // Back-to-back with req_valid held high.
      do_req(1, 1'b1, H, 1'b0, 32'h42, 32'h0000CAFE, "b2b sh", got);
      do_req(1, 1'b0, W, 1'b0, 32'h40, 32'h0, "b2b lw", got);
      chk("b2b lw const", got, 32'hCAFE5678);
      do_req(0, 1'b0, B, 1'b1, 32'h43, 32'h0, "b2b lbu", got);
      chk("b2b lbu const", got, 32'h000000CA);

      // Randomized traffic, occasionally back-to-back.
      for (int n = 0; n < 80; n++) begin
         do_req(($urandom % 3) == 0, 1'($urandom), 2'($urandom), 1'($urandom),
                32'($urandom % 1024), $urandom, $sformatf("rnd%0d", n), got);
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("final idle", 32'(req_ready), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
